// File: rtl/regfile_ctrl_pkg.sv
// Shared types and helpers for the multi-read-port register file controller.
// Holds the scrub FSM state type, the depth helper and a packed-field slicer.
package regfile_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Extract field idx of width w (w <= 32) from a packed vector.
    function automatic logic [31:0] port_field(
        input logic [255:0] vec,
        input int           idx,
        input int           w
    );
        logic [255:0] sh;
        sh = vec >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/regfile_ctrl_mp_rd_port.sv
// One read port: latency register, bypass mux, collision flag and output mask.
// Ports: clk/resetn, busy, ren/rad, write snoop (wen/wad/din), array data and
// valid for rad, lower-port read-read hit, coll_clr; outputs dout/dvalid/coll.
module regfile_rd_port #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter bit BYPASS       = 1'b1,
    parameter bit MASK_ON_COLL = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  busy,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] rad,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] wad,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    input  logic                  rr_hit,
    input  logic                  coll_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    output logic                  coll_status
);
    import regfile_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  wr_hit;
    logic                  coll_set;

    assign wr_hit = wen && (wad == rad);

    always_comb begin
        rd_val = '0;
        if (BYPASS && wr_hit) begin
            rd_val = din;
        end else if (rvalid) begin
            rd_val = rdata;
        end
    end

    assign coll_set = !busy && ren && (rr_hit || (!BYPASS && wr_hit));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout_q      <= '0;
            dvalid      <= 1'b0;
            coll_status <= 1'b0;
        end else begin
            if (ren) begin
                dout_q <= busy ? '0 : rd_val;
                dvalid <= !busy;
            end
            // A new collision beats a clear in the same cycle.
            coll_status <= coll_set || (coll_status && !coll_clr);
        end
    end

    assign dout = (MASK_ON_COLL && coll_status) ? '0 : dout_q;

endmodule

// File: rtl/regfile_ctrl_mp.sv
// Multi-read-port register file controller with valid bits and scrub FSM.
// Ports: clk/resetn, write (wen/wad/din), packed reads (ren/rad -> dout/
// dvalid), sticky coll_status with coll_clr, scrub_req/busy, wr_drop pulse.
module regfile_ctrl_mp #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD       = 2,
    parameter bit BYPASS       = 1'b1,
    parameter bit MASK_ON_COLL = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        wad,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            dvalid,
    output logic [NUM_RD-1:0]            coll_status,
    input  logic [NUM_RD-1:0]            coll_clr,
    input  logic                         scrub_req,
    output logic                         busy,
    output logic                         wr_drop
);
    import regfile_ctrl_pkg::*;

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    scrub_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] scrub_cnt, scrub_cnt_nxt;

    logic [ADDR_WIDTH-1:0] rad_a [NUM_RD];
    logic [NUM_RD-1:0]     rr_hit;

    assign busy = (state == SCRUB);

    always_comb begin
        state_nxt     = state;
        scrub_cnt_nxt = scrub_cnt;
        unique case (state)
            IDLE: begin
                if (scrub_req) begin
                    state_nxt = SCRUB;
                end
            end
            SCRUB: begin
                if (scrub_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt     = IDLE;
                    scrub_cnt_nxt = '0;
                end else begin
                    scrub_cnt_nxt = scrub_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = SCRUB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            valid     <= '0;
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_nxt;
            scrub_cnt <= scrub_cnt_nxt;
            wr_drop   <= busy && wen;
            if (busy) begin
                valid[scrub_cnt] <= 1'b0;
            end else if (wen) begin
                valid[wad] <= 1'b1;
            end
        end
    end

    // Data array has no reset; the scrub pass zeroes it.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (busy) begin
                mem[scrub_cnt] <= '0;
            end else if (wen) begin
                mem[wad] <= din;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rad
        assign rad_a[i] = ADDR_WIDTH'(port_field(256'(rad), i, ADDR_WIDTH));
    end

    // Port i is hit when any lower-index enabled port reads the same address.
    always_comb begin
        rr_hit = '0;
        for (int i = 1; i < NUM_RD; i++) begin
            for (int j = 0; j < i; j++) begin
                if (ren[j] && (rad_a[j] == rad_a[i])) begin
                    rr_hit[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        regfile_rd_port #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .BYPASS      (BYPASS),
            .MASK_ON_COLL(MASK_ON_COLL)
        ) u_port (
            .clk        (clk),
            .resetn     (resetn),
            .busy       (busy),
            .ren        (ren[i]),
            .rad        (rad_a[i]),
            .wen        (wen),
            .wad        (wad),
            .din        (din),
            .rdata      (mem[rad_a[i]]),
            .rvalid     (valid[rad_a[i]]),
            .rr_hit     (rr_hit[i]),
            .coll_clr   (coll_clr[i]),
            .dout       (dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .dvalid     (dvalid[i]),
            .coll_status(coll_status[i])
        );
    end

endmodule

// File: tb/tb_regfile_ctrl_mp.sv
// Directed bench for regfile_ctrl_mp: one BYPASS=1 and one BYPASS=0 instance
// share all inputs; outputs are checked 1ns after each rising edge.
module tb_regfile_ctrl_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wen;
    logic [4:0]  wad;
    logic [15:0] din;
    logic [1:0]  ren;
    logic [9:0]  rad;
    logic [1:0]  coll_clr;
    logic        scrub_req;

    logic [31:0] dout_a, dout_b;
    logic [1:0]  dvalid_a, dvalid_b;
    logic [1:0]  coll_a, coll_b;
    logic        busy_a, busy_b;
    logic        drop_a, drop_b;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    regfile_ctrl_mp #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .wen(wen), .wad(wad), .din(din),
        .ren(ren), .rad(rad), .dout(dout_a), .dvalid(dvalid_a),
        .coll_status(coll_a), .coll_clr(coll_clr), .scrub_req(scrub_req),
        .busy(busy_a), .wr_drop(drop_a)
    );

    regfile_ctrl_mp #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .wen(wen), .wad(wad), .din(din),
        .ren(ren), .rad(rad), .dout(dout_b), .dvalid(dvalid_b),
        .coll_status(coll_b), .coll_clr(coll_clr), .scrub_req(scrub_req),
        .busy(busy_b), .wr_drop(drop_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; wen = 1'b0; wad = '0; din = '0;
        ren = '0; rad = '0; coll_clr = '0; scrub_req = 1'b0;
        tick(); tick();
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_dvalid_a", {30'd0, dvalid_a}, 32'h0);
        chk("rst_coll_a", {30'd0, coll_a}, 32'h0);
        chk("rst_wr_drop", {31'd0, drop_a}, 32'h0);
        chk("rst_busy", {31'd0, busy_a}, 32'h1);

        // Post-reset scrub with a dropped write in cycle 3.
        resetn = 1'b1;
        n = 0;
        do begin
            if (n == 3) begin
                wen = 1'b1; wad = 5'd3; din = 16'hBEEF;
            end else begin
                wen = 1'b0;
            end
            tick();
            n++;
            if (n == 4) chk("wr_drop_pulse", {31'd0, drop_a}, 32'h1);
            if (n == 5) chk("wr_drop_end", {31'd0, drop_a}, 32'h0);
        end while (busy_a && n < 100);
        wen = 1'b0;
        chk("scrub_len", n, 32);
        chk("scrub_len_b", {31'd0, busy_b}, 32'h0);

        for (int a = 0; a < 32; a++) begin
            ren = 2'b01; rad = {5'd0, 5'(a)};
            tick();
            chk($sformatf("scrub_rd_%0d", a),
                {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h10000);
        end
        ren = 2'b00;

        // Basic write then read; never-written address reads 0.
        wen = 1'b1; wad = 5'd7; din = 16'hA5A5;
        tick();
        wen = 1'b0; ren = 2'b01; rad = {5'd0, 5'd7};
        tick();
        chk("rd7_a", {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h1A5A5);
        chk("rd7_b", {15'd0, dvalid_b[0], dout_b[15:0]}, 32'h1A5A5);
        rad = {5'd0, 5'd9};
        tick();
        chk("rd9", {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h10000);
        ren = 2'b00; rad = {5'd0, 5'd7};
        tick();
        chk("hold", {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h10000);

        // Write/read same address in one cycle on port 1.
        wen = 1'b1; wad = 5'd4; din = 16'h1234;
        ren = 2'b10; rad = {5'd4, 5'd0};
        tick();
        chk("byp_dout_a", {16'd0, dout_a[31:16]}, 32'h1234);
        chk("byp_coll_a", {30'd0, coll_a}, 32'h0);
        chk("raw_coll_b", {30'd0, coll_b}, 32'h2);
        chk("raw_dout_b", {16'd0, dout_b[31:16]}, 32'h0);
        wen = 1'b0; ren = 2'b00; coll_clr = 2'b10;
        tick();
        coll_clr = 2'b00;
        chk("raw_clr_b", {30'd0, coll_b}, 32'h0);
        chk("raw_old_b", {15'd0, dvalid_b[1], dout_b[31:16]}, 32'h10000);
        ren = 2'b10;
        tick();
        chk("rd4_b", {16'd0, dout_b[31:16]}, 32'h1234);

        // Read-read collision, then clear.
        wen = 1'b1; wad = 5'd12; din = 16'h0C0C; ren = 2'b00;
        tick();
        wen = 1'b0; ren = 2'b11; rad = {5'd12, 5'd12};
        tick();
        chk("rr_coll", {30'd0, coll_a}, 32'h2);
        chk("rr_dout", dout_a, 32'h00000C0C);
        chk("rr_dvalid", {30'd0, dvalid_a}, 32'h3);
        ren = 2'b00; coll_clr = 2'b10;
        tick();
        coll_clr = 2'b00;
        chk("rr_clr", {30'd0, coll_a}, 32'h0);
        chk("rr_unmask", dout_a, 32'h0C0C0C0C);

        // Set beats clear in the same cycle.
        ren = 2'b11; coll_clr = 2'b10;
        tick();
        ren = 2'b00; coll_clr = 2'b00;
        chk("set_wins", {30'd0, coll_a}, 32'h2);
        coll_clr = 2'b11;
        tick();
        coll_clr = 2'b00;

        // Mid-scrub reset restarts a full scrub.
        wen = 1'b1; wad = 5'd20; din = 16'h2020;
        tick();
        wen = 1'b0; ren = 2'b01; rad = {5'd0, 5'd20};
        tick();
        ren = 2'b00;
        chk("rd20_pre", {16'd0, dout_a[15:0]}, 32'h2020);
        scrub_req = 1'b1;
        tick();
        scrub_req = 1'b0;
        chk("req_busy", {31'd0, busy_a}, 32'h1);
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_mid_busy", {31'd0, busy_a}, 32'h1);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_a && n < 100);
        chk("rescrub_len", n, 32);
        ren = 2'b01; rad = {5'd0, 5'd20};
        tick();
        chk("rd20_post", {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h10000);
        rad = {5'd0, 5'd7};
        tick();
        chk("rd7_post", {15'd0, dvalid_a[0], dout_a[15:0]}, 32'h10000);
        ren = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl_mp.md
Name: regfile_ctrl_mp

Overview:
- Parametrised multi-read-port register file controller: one write port, NUM_RD synchronous read ports, per-entry valid bits, optional write-to-read bypass.
- Per-port sticky collision status with software clear.
- Scrub FSM zeroes the data array after reset and on request.
- Sits between the datapath and register storage as the general replacement for the fixed 2-read, 32-entry, 16-bit controller.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (1..8).
- BYPASS, 1, 1: a read of the address being written returns din; 0: the read is flagged as a RAW collision.
- MASK_ON_COLL, 1, 1: dout of a port is forced to 0 while its status bit is set.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- wen  in  1  write enable.
- wad  in  ADDR_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- ren  in  NUM_RD  per-port read enable.
- rad  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- dout  out  NUM_RD*DATA_WIDTH  packed read data, same packing as rad.
- dvalid  out  NUM_RD  per-port read-data-valid.
- coll_status  out  NUM_RD  sticky per-port collision flags.
- coll_clr  in  NUM_RD  per-port clear of coll_status.
- scrub_req  in  1  start a scrub (level; sampled in IDLE only).
- busy  out  1  high while the scrub FSM is in SCRUB.
- wr_drop  out  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - all valid bits, dout, dvalid, coll_status and wr_drop go to 0;
  - the scrub counter goes to 0;
  - FSM goes to SCRUB, so busy=1 on the first cycle after reset.
- The data array itself is not reset; the scrub clears it.
- Scrub FSM states:
  - IDLE -> SCRUB when scrub_req=1; busy rises the next cycle.
  - SCRUB:
    - each cycle writes 0 to entry scrub_cnt, clears valid[scrub_cnt], and increments scrub_cnt;
    - at scrub_cnt=DEPTH-1, goes to IDLE and resets scrub_cnt to 0;
    - duration is exactly DEPTH cycles;
    - scrub_req is ignored while in SCRUB.
  - resetn=0 mid-scrub restarts the scrub from entry 0.
- While busy:
  - wen=1 -> write discarded; wr_drop=1 next cycle.
  - Reads return dout=0, dvalid=0.
  - Collision detection is inhibited.
- Write (IDLE, wen=1): entry wad <= din and valid[wad] <= 1 at the edge.
- Read latency is one cycle. For port i with ren[i]=1 in IDLE, the next cycle gives:
  - dvalid[i]=1;
  - dout[i] = data[rad_i] if valid[rad_i], else 0.
- Bypass:
  - With BYPASS=1 and wen=1, wad==rad_i: dout[i]=din (new data, valid treated as 1).
  - With BYPASS=0: returns the old content.
- ren[i]=0: dout[i] and dvalid[i] hold their previous values; dvalid is not a pulse.
- Collision set conditions for port i (IDLE, ren[i]=1):
  - (a) some j<i with ren[j]=1 and rad_j==rad_i (read-read; the lowest-index port is never flagged for read-read);
  - (b) BYPASS=0 and wen=1 and wad==rad_i (RAW).
  - When set, coll_status[i]=1 from the next cycle and stays set until cleared.
  - If set and coll_clr[i] occur in the same cycle, set wins.
  - coll_clr[i] alone clears the bit at the next edge.
- MASK_ON_COLL=1: dout[i] is combinationally 0 while coll_status[i]=1; dvalid is unaffected.
- Address wrap: none; all addresses are in range by construction.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - typedef scrub_state_t {IDLE, SCRUB};
  - a localparam function for DEPTH;
  - a helper function to slice packed port fields.
- One natural sub-module, regfile_rd_port: a single read port with its latency register, bypass mux, collision-set logic, status flop and mask. It is instantiated NUM_RD times in a generate loop.
- Storage, write logic and the scrub FSM stay in the top level.

Test Plan (defaults DATA_WIDTH=16, ADDR_WIDTH=5, NUM_RD=2):
- Post-reset scrub: release resetn -> busy=1 for exactly 32 cycles. A wen=1 at cycle 3 gives wr_drop=1 at cycle 4. After busy falls, reading addresses 0..31 gives dout=0, dvalid=1.
- Basic write/read: write 0xA5A5 to addr 7; next cycle ren[0]=1, rad0=7 -> the following cycle dout0=0xA5A5, dvalid[0]=1. A read of never-written addr 9 -> dout=0.
- Bypass: BYPASS=1, same cycle wen=1, wad=4, din=0x1234, ren[1]=1, rad1=4 -> next cycle dout1=0x1234, coll_status=0. Rebuild with BYPASS=0 -> dout1=old value (0) and coll_status[1]=1.
- Read-read collision: ren=2'b11, rad0=rad1=12 -> coll_status=2'b10, dout1 masked to 0, dout0 correct. Then coll_clr[1]=1 with no new collision -> coll_status=0 the next cycle.
- Clear vs set priority: coll_clr[1]=1 in the same cycle as a new rad0=rad1 collision -> coll_status[1] remains 1.
- Mid-scrub reset: scrub_req at cycle 0, resetn=0 at scrub cycle 10 -> after release busy lasts a full 32 cycles and all entries read 0; a previously written entry 20 also reads 0.
